// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the iterative floating-point divider.
// Holds FSM states, operand classes, flag bit positions and format-derived constants.
package fp_div_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} op_class_t;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_W         = 5;

  // Widest format the helpers can describe; callers truncate to their own width.
  localparam int MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand decode: field split and class, with subnormals read as zero.
module fp_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output op_class_t            cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_field,
  output logic [MAN_W:0]       man
);

  logic [MAN_W-1:0] frac;

  assign sign      = x[EXP_W+MAN_W];
  assign exp_field = x[EXP_W+MAN_W-1:MAN_W];
  assign frac      = x[MAN_W-1:0];
  assign man       = {1'b1, frac};

  always_comb begin
    cls = NORMAL;
    if (exp_field == '0) begin
      // Zero exponent covers both true zeros and flushed subnormals.
      cls = ZERO;
    end else if (&exp_field) begin
      if (frac == '0) begin
        cls = INF;
      end else if (frac[MAN_W-1]) begin
        cls = QNAN;
      end else begin
        cls = SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: radix-2 non-restoring, one quotient bit per clock,
// round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int RW = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 3);

  localparam logic [CW-1:0]        LAST_ITER = CW'(MAN_W + 2);
  localparam logic signed [EW-1:0] BIAS_E    = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] ONE_E     = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E    = EW'(0);
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));
  localparam logic [W-2:0]         INF_MAG   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  state_t state_reg, state_next;
  logic   accept, load_div, load_special;

  op_class_t      a_cls, b_cls;
  logic           a_sign, b_sign, sign_q;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0] a_man, b_man;

  logic           is_special;
  logic [W-1:0]   spec_result;
  logic [4:0]     spec_flags;

  logic signed [RW-1:0] rem_reg, rem_shift, rem_step, mb_ext;
  logic [RW-1:0]        quo_reg;
  logic [MAN_W:0]       mb_reg;
  logic [CW-1:0]        cnt_reg;
  logic signed [EW-1:0] exp_reg;
  logic                 sign_reg;

  logic [W-1:0] result_reg, round_result;
  logic [4:0]   flags_reg, round_flags;

  logic                 q_msb, guard, sticky, rem_nz, round_up, carry;
  logic [MAN_W-1:0]     frac_raw, frac_fin;
  logic signed [EW-1:0] exp_norm, exp_fin;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
    .x         (a),
    .cls       (a_cls),
    .sign      (a_sign),
    .exp_field (a_exp),
    .man       (a_man)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
    .x         (b),
    .cls       (b_cls),
    .sign      (b_sign),
    .exp_field (b_exp),
    .man       (b_man)
  );

  assign sign_q = a_sign ^ b_sign;

  // Special-case decode, first matching rule wins.
  always_comb begin
    is_special  = 1'b1;
    spec_result = '0;
    spec_flags  = '0;
    if (a_cls == QNAN || a_cls == SNAN || b_cls == QNAN || b_cls == SNAN) begin
      spec_result                = CANON_NAN;
      spec_flags[FLAG_INVALID]   = (a_cls == SNAN) || (b_cls == SNAN);
    end else if ((a_cls == ZERO && b_cls == ZERO) || (a_cls == INF && b_cls == INF)) begin
      spec_result                = CANON_NAN;
      spec_flags[FLAG_INVALID]   = 1'b1;
    end else if (a_cls == INF) begin
      spec_result                = {sign_q, INF_MAG};
    end else if (b_cls == ZERO) begin
      spec_result                = {sign_q, INF_MAG};
      spec_flags[FLAG_DIV_ZERO]  = 1'b1;
    end else if (a_cls == ZERO || b_cls == INF) begin
      spec_result                = {sign_q, {(W-1){1'b0}}};
    end else begin
      is_special                 = 1'b0;
    end
  end

  // Non-restoring step: the first iteration compares ma against mb unshifted.
  always_comb begin
    mb_ext    = {2'b00, mb_reg};
    rem_shift = (cnt_reg == '0) ? rem_reg : {rem_reg[RW-2:0], 1'b0};
    rem_step  = rem_reg[RW-1] ? (rem_shift + mb_ext) : (rem_shift - mb_ext);
  end

  // A negative partial remainder is the true remainder minus mb.
  assign rem_nz = rem_reg[RW-1] ? ((rem_reg + mb_ext) != '0) : (rem_reg != '0);

  always_comb begin
    q_msb    = quo_reg[RW-1];
    frac_raw = q_msb ? quo_reg[RW-2:2] : quo_reg[RW-3:1];
    guard    = q_msb ? quo_reg[1] : quo_reg[0];
    sticky   = rem_nz | (q_msb & quo_reg[0]);
    round_up = guard & (sticky | frac_raw[0]);
    // Carry out of the fraction means the significand rounded up to 2.0.
    {carry, frac_fin} = {1'b0, frac_raw} + {{MAN_W{1'b0}}, round_up};
    exp_norm = q_msb ? exp_reg : (exp_reg - ONE_E);
    exp_fin  = carry ? (exp_norm + ONE_E) : exp_norm;

    round_flags = '0;
    if (exp_fin >= EXP_MAX) begin
      round_result                = {sign_reg, INF_MAG};
      round_flags[FLAG_OVERFLOW]  = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
    end else if (exp_fin <= ZERO_E) begin
      round_result                = {sign_reg, {(W-1){1'b0}}};
      round_flags[FLAG_UNDERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      round_result                = {sign_reg, exp_fin[EXP_W-1:0], frac_fin};
      round_flags[FLAG_INEXACT]   = guard | sticky;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = is_special ? DONE : DIV;
      DIV:     if (cnt_reg == LAST_ITER) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_reg == IDLE);
    out_valid    = (state_reg == DONE);
    accept       = in_ready & in_valid;
    load_div     = accept & ~is_special;
    load_special = accept & is_special;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg    <= '0;
      quo_reg    <= '0;
      mb_reg     <= '0;
      cnt_reg    <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      if (load_div) begin
        rem_reg  <= {2'b00, a_man};
        quo_reg  <= '0;
        mb_reg   <= b_man;
        cnt_reg  <= '0;
        exp_reg  <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS_E;
        sign_reg <= sign_q;
      end
      if (load_special) begin
        result_reg <= spec_result;
        flags_reg  <= spec_flags;
      end
      if (state_reg == DIV) begin
        rem_reg <= rem_step;
        quo_reg <= {quo_reg[RW-2:0], ~rem_step[RW-1]};
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == ROUND) begin
        result_reg <= round_result;
        flags_reg  <= round_flags;
      end
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed vector table, handshake and reset sequences,
// randomized binary32 ops against an exact-arithmetic model, and one binary64 op.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, result32;
  logic [4:0]  flags32;
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] a64, b64, result64;
  logic [4:0]  flags64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
    .result(result32), .flags(flags32)
  );

  fp_div_iter #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
    .result(result64), .flags(flags64)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Exact reference: integer long division with a half-ulp remainder compare for RNE.
  function automatic void ref_div32(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [4:0] fl,
                                    output bit special);
    logic s;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    longint unsigned ma, mb, num, q, r;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    a_zero = (ea == 0); b_zero = (eb == 0);
    a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
    a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
    a_snan = a_nan && !fa[22]; b_snan = b_nan && !fb[22];
    special = 1; fl = 5'h00; res = 32'h0;
    if (a_nan || b_nan) begin
      res = 32'h7FC00000; fl[4] = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      res = 32'h7FC00000; fl[4] = 1'b1;
    end else if (a_inf) begin
      res = {s, 8'hFF, 23'h0};
    end else if (b_zero) begin
      res = {s, 8'hFF, 23'h0}; fl[3] = 1'b1;
    end else if (a_zero || b_inf) begin
      res = {s, 31'h0};
    end else begin
      special = 0;
      ma = 64'(fa) | (64'd1 << 23);
      mb = 64'(fb) | (64'd1 << 23);
      sh = (ma < mb) ? 1 : 0;
      num = ma << (23 + sh);
      q = num / mb;
      r = num % mb;
      e = ea - eb + 127 - sh;
      if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'h0}; fl = 5'h05;
      end else if (e <= 0) begin
        res = {s, 31'h0}; fl = 5'h03;
      end else begin
        res = {s, 8'(e), q[22:0]}; fl = {4'h0, r != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic [31:0] v;
    k = $urandom_range(0, 15);
    v = $urandom;
    if (k == 0) begin
      v[30:23] = 8'h00;
    end else if (k == 1) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 1) v[22:0] = 23'h0;
    end else if (k < 12) begin
      v[30:23] = 8'(107 + $urandom_range(0, 40));
    end
    return v;
  endfunction

  // One complete transaction on dut32 with out_ready held high; lat = -1 on timeout.
  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [4:0] fl, output int lat);
    int w;
    w = 0;
    while (!in_ready32 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    a32 = a; b32 = b; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 1;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result32; fl = flags32;
    if (!out_valid32) lat = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] res, exp_res;
    logic [4:0]  fl, exp_fl;
    bit          special;
    int          lat, seen;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28};
    vecs[2]  = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'h01, 28};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 1};
    vecs[5]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1};
    vecs[6]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 5'h00, 1};
    vecs[7]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05, 28};
    vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000, 5'h03, 28};
    vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'h00, 1};
    vecs[10] = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'h00, 1};
    vecs[11] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10, 1};
    vecs[12] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 5'h00, 1};
    vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 5'h00, 1};
    vecs[14] = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 5'h00, 28};

    rst_n = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; out_ready64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready32), 64'd1);
    check("reset_out_valid", 64'(out_valid32), 64'd0);
    check("reset_result", 64'(result32), 64'd0);
    check("reset_flags", 64'(flags32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run32(vecs[i].a, vecs[i].b, res, fl, lat);
      $display("vec %0d: %h / %h -> %h flags %b lat %0d", i, vecs[i].a, vecs[i].b, res, fl, lat);
      check("vec_result", 64'(res), 64'(vecs[i].res));
      check("vec_flags", 64'(fl), 64'(vecs[i].fl));
      check("vec_latency", 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure: result must hold and new requests must be ignored.
    out_ready32 = 1'b0;
    a32 = 32'h40C00000; b32 = 32'h40000000; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("hold_latency", 64'(lat), 64'd28);
    for (int i = 0; i < 10; i++) begin
      in_valid32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40400000;
      @(posedge clk); #1;
      check("hold_result", 64'(result32), 64'h40400000);
      check("hold_flags", 64'(flags32), 64'd0);
      check("hold_in_ready", 64'(in_ready32), 64'd0);
      check("hold_out_valid", 64'(out_valid32), 64'd1);
    end
    $display("hold: released after 10 stalled cycles, result %h", result32);
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(in_ready32), 64'd1);
    check("release_out_valid", 64'(out_valid32), 64'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid32) seen++;
    end
    check("ignored_request", 64'(seen), 64'd0);

    // Reset in the middle of the iteration phase aborts the operation.
    a32 = 32'h40C00000; b32 = 32'h40000000; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready32), 64'd1);
    check("abort_out_valid", 64'(out_valid32), 64'd0);
    check("abort_result", 64'(result32), 64'd0);
    check("abort_flags", 64'(flags32), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (32) begin
      @(posedge clk); #1;
      if (out_valid32) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    run32(32'h40C00000, 32'h40000000, res, fl, lat);
    $display("after reset: 40c00000 / 40000000 -> %h flags %b lat %0d", res, fl, lat);
    check("post_reset_result", 64'(res), 64'h40400000);
    check("post_reset_flags", 64'(fl), 64'd0);
    check("post_reset_latency", 64'(lat), 64'd28);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      ref_div32(ra, rb, exp_res, exp_fl, special);
      run32(ra, rb, res, fl, lat);
      $display("rand %0d: %h / %h -> %h flags %b lat %0d", i, ra, rb, res, fl, lat);
      check("rand_result", 64'(res), 64'(exp_res));
      check("rand_flags", 64'(fl), 64'(exp_fl));
      check("rand_latency", 64'(lat), special ? 64'd1 : 64'd28);
    end

    check("dp_in_ready", 64'(in_ready64), 64'd1);
    a64 = 64'h3FF0000000000000; b64 = 64'h4008000000000000; in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    $display("dp: 3ff0000000000000 / 4008000000000000 -> %h flags %b lat %0d", result64, flags64, lat);
    check("dp_result", result64, 64'h3FD5555555555555);
    check("dp_flags", 64'(flags64), 64'h01);
    check("dp_latency", 64'(lat), 64'd57);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
